// File: rtl/snn_frame_loader.sv
// Byte-stream to bit-RAM unpacker for the SNN input frame: each received byte
// becomes eight LSB-first pixel writes, and a full frame fires one start pulse.
module snn_frame_loader #(
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              core_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_din,
    output logic              ram_we,
    output logic              start,
    output logic              busy,
    output logic              overrun
);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    logic [1:0]        state_r, state_s;
    logic [7:0]        sh_r, sh_s;
    logic [2:0]        bit_cnt_r, bit_cnt_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic              start_r, start_s;
    logic              ovr_r, ovr_s;

    // Next-state logic: a byte is only taken in LOAD; anything arriving otherwise is an overrun.
    always_comb begin
        state_s   = state_r;
        sh_s      = sh_r;
        bit_cnt_s = bit_cnt_r;
        addr_s    = addr_r;
        start_s   = 1'b0;
        ovr_s     = ovr_r;
        case (state_r)
            ST_LOAD: begin
                if (rx_rdy) begin
                    sh_s      = rx_data;
                    bit_cnt_s = 3'd0;
                    state_s   = ST_SHIFT;
                end else begin
                    state_s   = ST_LOAD;
                end
            end
            ST_SHIFT: begin
                sh_s      = {1'b0, sh_r[7:1]};
                addr_s    = addr_r + ADDR_ONE;
                bit_cnt_s = bit_cnt_r + 3'd1;
                if (rx_rdy) begin
                    ovr_s = 1'b1;
                end else begin
                    ovr_s = ovr_r;
                end
                if (bit_cnt_r == 3'd7) begin
                    if (addr_r == LAST_ADDR) begin
                        start_s = 1'b1;
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                // Release wins over a simultaneous stray byte, so the flag ends cleared.
                if (core_done) begin
                    addr_s  = '0;
                    ovr_s   = 1'b0;
                    state_s = ST_LOAD;
                end else if (rx_rdy) begin
                    ovr_s   = 1'b1;
                end else begin
                    ovr_s   = ovr_r;
                end
            end
            default: begin
                state_s = ST_LOAD;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_LOAD;
            sh_r      <= 8'h00;
            bit_cnt_r <= 3'd0;
            addr_r    <= '0;
            start_r   <= 1'b0;
            ovr_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            sh_r      <= sh_s;
            bit_cnt_r <= bit_cnt_s;
            addr_r    <= addr_s;
            start_r   <= start_s;
            ovr_r     <= ovr_s;
        end
    end

    assign ram_addr = addr_r;
    assign ram_din  = sh_r[0];
    assign ram_we   = (state_r == ST_SHIFT);
    assign busy     = (state_r != ST_LOAD);
    assign start    = start_r;
    assign overrun  = ovr_r;

endmodule

// File: doc/snn_frame_loader.md
# snn_frame_loader

Upstream feeder for the SNN inference core. Consumes the byte stream from the UART receiver and unpacks each byte LSB-first into the 1-bit-wide input RAM: 98 bytes give 784 single-bit writes, one per pixel. When the last pixel is written, the block issues a one-cycle start pulse to the core. It then holds off further input until the core reports done.

## Interface
Parameters:
- NUM_BITS, default 784: pixels per frame. Must be a multiple of 8.
- ADDR_W, default 10: RAM address width. Must satisfy 2^ADDR_W ≥ NUM_BITS.

Ports:
- clk  input  1  system clock (50 MHz). Single clock domain.
- rst  input  1  asynchronous, active-high reset.
- rx_rdy  input  1  one-cycle strobe from the UART receiver; rx_data is valid in the same cycle.
- rx_data  input  8  received byte. Bit 0 is the lowest-addressed pixel.
- core_done  input  1  one-cycle pulse from the SNN core; releases the frame hold.
- ram_addr  output  ADDR_W  input-RAM write address.
- ram_din  output  1  input-RAM write data.
- ram_we  output  1  input-RAM write enable.
- start  output  1  one-cycle pulse: frame fully written, core may begin.
- busy  output  1  high while unpacking a byte or holding a completed frame.
- overrun  output  1  sticky flag: a byte arrived when it could not be accepted.

## Operation
Registers:
- state (LOAD, SHIFT, HOLD).
- sh[7:0], byte shift register.
- bit_cnt[2:0].
- addr[ADDR_W-1:0].
- start_r.
- ovr_r.

Output mapping: ram_addr = addr, ram_din = sh[0], ram_we = (state==SHIFT), busy = (state!=LOAD), start = start_r, overrun = ovr_r. No output depends combinationally on any input.

State behaviour:
- LOAD: on rx_rdy, sh←rx_data, bit_cnt←0, go to SHIFT. Otherwise stay.
- SHIFT: every cycle one RAM write occurs at addr. Then sh←sh>>1, addr←addr+1, bit_cnt←bit_cnt+1.
  - On the cycle with bit_cnt==7: if addr==NUM_BITS-1, set start_r←1 and go to HOLD; otherwise go to LOAD.
  - addr saturates conceptually at NUM_BITS. It is reset to 0 only on HOLD exit.
- HOLD: no RAM writes. On core_done: addr←0, ovr_r←0, go to LOAD.
- start_r is cleared on every cycle in which it is not being set.

Boundary cases:
- rx_rdy while in SHIFT or HOLD: the byte is dropped, ovr_r←1, and no state, addr or sh change. Accepting a byte on the last SHIFT cycle also counts as overrun. Bytes are accepted in LOAD only.
- core_done while in LOAD or SHIFT: ignored.
- rx_rdy and core_done in the same HOLD cycle: the release happens (ovr_r←0) and the byte is dropped. ovr_r ends at 0 because the release clear has priority.
- rst at any time, including mid-byte or mid-frame, immediately forces the reset values below. The partial frame is discarded and the next frame writes from address 0.

## Timing
Reset values:
- ram_addr=0, ram_din=0, ram_we=0, start=0, busy=0, overrun=0.
- state=LOAD, sh=8'h00, bit_cnt=0.

Latency:
- rx_rdy at cycle T gives write cycles T+1..T+8, at addresses a..a+7 with data rx_data[0..7].
- busy is high from T+1.
- For the final byte, start is high at T+9 only, and busy stays high from T+1 until the cycle after core_done.
- core_done at cycle C: LOAD at C+1, busy=0 and ram_addr=0 at C+1. The next rx_rdy is accepted at C+1.

Throughput:
- Minimum accepted byte spacing is 9 cycles. At 115200 baud the UART byte period is about 4340 cycles, so overrun signals a system fault, not a normal condition.
- A full frame is 784 write cycles plus the UART time.

## Test plan
1. Reset check: assert rst for 3 cycles with random inputs → all outputs 0. First rx_rdy after release writes at addr 0.
2. Single byte 8'hA5 → we high exactly at T+1..T+8; addr 0..7; din 1,0,1,0,0,1,0,1. Back in LOAD at T+9 with busy=0 and start=0.
3. Full frame of 98 bytes, alternating 8'hFF and 8'h00, spaced 20 cycles → 784 writes at addr 0..783 with the correct bit pattern. Exactly one start pulse, at the cycle after the addr-783 write. busy stays high until core_done.
4. Overrun: a second rx_rdy 3 cycles after the first, then an rx_rdy while in HOLD → overrun=1, no extra writes, addr sequence undisturbed. core_done clears overrun and the next frame restarts at addr 0.
5. Mid-frame reset: assert rst during the SHIFT of byte 40 → outputs reset asynchronously. The following 98-byte frame writes addr 0..783 and asserts start once.
6. Stray core_done in LOAD and in SHIFT → ignored; addr, state and writes unchanged, start never asserted.
